// File: rtl/carfield_reg_arb.sv
// Round-robin arbiter sharing the Carfield external register port among NumReq requesters.
// Optional stalled-access abort enabled by defining CARFIELD_REG_ARB_TIMEOUT_EN.
module carfield_reg_arb #(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 256,
  localparam int unsigned StrbWidth    = DataWidth / 8,
  localparam int unsigned IdxWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  input  logic [NumReq-1:0]                   req_write_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
  input  logic [NumReq-1:0][StrbWidth-1:0]    req_wstrb_i,
  output logic [NumReq-1:0]                   req_ready_o,
  output logic [DataWidth-1:0]                req_rdata_o,
  output logic [NumReq-1:0]                   req_error_o,
  output logic                                dev_valid_o,
  output logic                                dev_write_o,
  output logic [AddrWidth-1:0]                dev_addr_o,
  output logic [DataWidth-1:0]                dev_wdata_o,
  output logic [StrbWidth-1:0]                dev_wstrb_o,
  input  logic                                dev_ready_i,
  input  logic [DataWidth-1:0]                dev_rdata_i,
  input  logic                                dev_error_i,
  output logic                                timeout_o,
  output logic [IdxWidth-1:0]                 grant_idx_o
);

  if (NumReq < 2 || TimeoutCycles < 2) begin : g_bad_cfg
    $error("carfield_reg_arb: NumReq and TimeoutCycles must both be >= 2");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state;
  logic [IdxWidth-1:0] rr_ptr, grant_q, winner, ptr_next;
  logic [IdxWidth:0]   idx;
  logic                any_valid, busy, done, abort;

  // First valid requester at or above rr_ptr, wrapping at NumReq.
  always_comb begin
    winner    = rr_ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = {1'b0, rr_ptr} + (IdxWidth+1)'(i);
      if (idx >= (IdxWidth+1)'(NumReq)) idx = idx - (IdxWidth+1)'(NumReq);
      if (!any_valid && req_valid_i[idx[IdxWidth-1:0]]) begin
        winner    = idx[IdxWidth-1:0];
        any_valid = 1'b1;
      end
    end
  end

  assign ptr_next = (grant_q == IdxWidth'(NumReq-1)) ? '0 : grant_q + IdxWidth'(1);
  assign busy     = (state == BUSY);
  assign done     = busy && dev_ready_i;

`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles);
  logic [CntWidth-1:0] cnt_q;
  // A late dev_ready_i in the final cycle still wins over the abort.
  assign abort = busy && !dev_ready_i && (cnt_q == CntWidth'(TimeoutCycles-1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant_q <= '0;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          grant_q <= winner;
          state   <= BUSY;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        BUSY: if (done || abort) begin
          rr_ptr <= ptr_next;
          state  <= IDLE;
        end else begin
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
          cnt_q  <= cnt_q + CntWidth'(1);
`endif
        end
      endcase
    end
  end

  assign dev_valid_o = busy;
  assign dev_write_o = busy && req_write_i[grant_q];
  assign dev_addr_o  = busy ? req_addr_i[grant_q]  : '0;
  assign dev_wdata_o = busy ? req_wdata_i[grant_q] : '0;
  assign dev_wstrb_o = busy ? req_wstrb_i[grant_q] : '0;

  always_comb begin
    req_ready_o = '0;
    req_error_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_q == IdxWidth'(i)) begin
        req_ready_o[i] = done || abort;
        req_error_o[i] = done ? dev_error_i : abort;
      end
    end
  end

  assign req_rdata_o = done ? dev_rdata_i : '0;
  assign timeout_o   = abort;
  assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_carfield_reg_arb.sv
// Directed bench for carfield_reg_arb; timeout steps run only with CARFIELD_REG_ARB_TIMEOUT_EN.
module tb_carfield_reg_arb;
`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam int          STALL = 2;
`else
  localparam int unsigned TO    = 256;
  localparam int          STALL = 5;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        rv, rw;
  logic [2:0][47:0]  ra;
  logic [2:0][31:0]  wd;
  logic [2:0][3:0]   ws;
  logic [2:0]        req_ready, req_error;
  logic [31:0]       req_rdata;
  logic              dev_valid, dev_write, dev_ready, dev_error, timeout;
  logic [47:0]       dev_addr;
  logic [31:0]       dev_wdata, dev_rdata;
  logic [3:0]        dev_wstrb;
  logic [1:0]        grant_idx;
  int                total = 0;
  int                bad   = 0;

  carfield_reg_arb #(.NumReq(3), .AddrWidth(48), .DataWidth(32), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(rv), .req_write_i(rw), .req_addr_i(ra), .req_wdata_i(wd), .req_wstrb_i(ws),
    .req_ready_o(req_ready), .req_rdata_o(req_rdata), .req_error_o(req_error),
    .dev_valid_o(dev_valid), .dev_write_o(dev_write), .dev_addr_o(dev_addr),
    .dev_wdata_o(dev_wdata), .dev_wstrb_o(dev_wstrb),
    .dev_ready_i(dev_ready), .dev_rdata_i(dev_rdata), .dev_error_i(dev_error),
    .timeout_o(timeout), .grant_idx_o(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rv = '0; rw = '0; ra = '0; wd = '0; ws = '0;
    dev_ready = 1'b0; dev_rdata = '0; dev_error = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dev_valid", 64'(dev_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_grant_idx", 64'(grant_idx), 64'(0));
    chk("rst_timeout",   64'(timeout),   64'(0));
    tick();

    // single read by requester 1
    rv = 3'b010; rw = 3'b000; ra[1] = 48'h1000;
    @(negedge clk); chk("rd_arb_cycle", 64'(dev_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("rd_dev_valid", 64'(dev_valid), 64'(1));
    chk("rd_dev_addr",  64'(dev_addr),  64'h1000);
    chk("rd_grant",     64'(grant_idx), 64'(1));
    chk("rd_wait_rdy",  64'(req_ready), 64'(0));
    tick();
    dev_ready = 1'b1; dev_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("rd_ready", 64'(req_ready), 64'(3'b010));
    chk("rd_rdata", 64'(req_rdata), 64'hCAFE_0001);
    tick();
    rv = '0; dev_ready = 1'b0; dev_rdata = '0;
    @(negedge clk);
    chk("rd_idle_valid", 64'(dev_valid), 64'(0));
    chk("rd_idle_rdata", 64'(req_rdata), 64'(0));
    tick();

    // fairness: fresh reset, all valid, zero-wait slave
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0; rv = 3'b111; dev_ready = 1'b1;
    ra[0] = 48'h40; ra[1] = 48'h140; ra[2] = 48'h240;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("fair_idle_ready", 64'(req_ready), 64'(0));
      chk("fair_idle_valid", 64'(dev_valid), 64'(0));
      tick();
      @(negedge clk);
      chk("fair_grant", 64'(grant_idx), 64'(k % 3));
      chk("fair_ready", 64'(req_ready), 64'(1) << (k % 3));
      chk("fair_addr",  64'(dev_addr),  64'h40 + 64'h100 * 64'(k % 3));
      tick();
    end
    rv = '0; dev_ready = 1'b0;
    @(negedge clk);
    tick();

    // write by requester 2 with stalled slave; valid dropped mid-access
    rv = 3'b100; rw = 3'b100; ra[2] = 48'h20; wd[2] = 32'hA5A5_A5A5; ws[2] = 4'b0011;
    @(negedge clk); chk("wr_arb_cycle", 64'(dev_valid), 64'(0));
    tick();
    for (int c = 0; c <= STALL; c++) begin
      if (c == 2) rv = 3'b000;
      if (c == STALL) dev_ready = 1'b1;
      @(negedge clk);
      chk("wr_fields", 64'({dev_valid, dev_write, dev_wstrb, dev_wdata}),
          64'({1'b1, 1'b1, 4'b0011, 32'hA5A5_A5A5}));
      chk("wr_addr",  64'(dev_addr), 64'h20);
      chk("wr_ready", 64'(req_ready), (c == STALL) ? 64'(3'b100) : 64'(0));
      chk("wr_no_timeout", 64'(timeout), 64'(0));
      tick();
    end
    dev_ready = 1'b0; rw = '0;
    @(negedge clk);
    chk("wr_after_valid", 64'(dev_valid), 64'(0));
    chk("wr_after_ready", 64'(req_ready), 64'(0));
    tick();

    // error pass-through on requester 0
    rv = 3'b001; ra[0] = 48'h30; dev_error = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("err_pre_error", 64'(req_error), 64'(0));
    chk("err_pre_ready", 64'(req_ready), 64'(0));
    tick();
    dev_ready = 1'b1;
    @(negedge clk);
    chk("err_ready", 64'(req_ready), 64'(3'b001));
    chk("err_error", 64'(req_error), 64'(3'b001));
    tick();
    rv = '0;
    @(negedge clk);
    chk("err_idle_error", 64'(req_error), 64'(0));
    chk("err_idle_ready", 64'(req_ready), 64'(0));
    tick();
    dev_ready = 1'b0; dev_error = 1'b0;

`ifdef CARFIELD_REG_ARB_TIMEOUT_EN
    // slave never answers: abort in the 4th BUSY cycle
    rv = 3'b010; dev_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tick();
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      if (b < 4) begin
        chk("to_wait_ready",   64'(req_ready), 64'(0));
        chk("to_wait_timeout", 64'(timeout),   64'(0));
      end else begin
        chk("to_ready",   64'(req_ready), 64'(3'b010));
        chk("to_error",   64'(req_error), 64'(3'b010));
        chk("to_timeout", 64'(timeout),   64'(1));
        chk("to_rdata",   64'(req_rdata), 64'(0));
      end
      tick();
    end
    rv = '0;
    @(negedge clk);
    chk("to_idle_valid",   64'(dev_valid), 64'(0));
    chk("to_idle_timeout", 64'(timeout),   64'(0));
    tick();
    // answer lands exactly in the 4th cycle: normal completion wins
    rv = 3'b100; rw = 3'b000;
    @(negedge clk);
    tick();
    for (int b = 1; b <= 4; b++) begin
      if (b == 4) dev_ready = 1'b1;
      @(negedge clk);
      chk("tw_timeout", 64'(timeout), 64'(0));
      if (b == 4) begin
        chk("tw_ready", 64'(req_ready), 64'(3'b100));
        chk("tw_error", 64'(req_error), 64'(0));
        chk("tw_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
      end
      tick();
    end
    rv = '0; dev_ready = 1'b0; dev_rdata = '0;
    @(negedge clk);
    tick();
`endif

    // reset in the 2nd BUSY cycle drops the access
    rv = 3'b010;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rm_busy1", 64'(dev_valid), 64'(1));
    tick();
    rst = 1'b1; rv = 3'b011;
    @(negedge clk);
    chk("rm_busy2_ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rm_after_valid", 64'(dev_valid), 64'(0));
    chk("rm_after_ready", 64'(req_ready), 64'(0));
    chk("rm_after_grant", 64'(grant_idx), 64'(0));
    tick();
    @(negedge clk);
    chk("rm_regrant",      64'(grant_idx), 64'(0));
    chk("rm_regrant_addr", 64'(dev_addr),  64'h30);
    tick();
    dev_ready = 1'b1;
    @(negedge clk);
    chk("rm_regrant_ready", 64'(req_ready), 64'(3'b001));
    tick();
    rv = '0; dev_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
